wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Registered write-back stage for the pipelined core.
- Selects the register-file write data from four sources: ALU result, load data, PC+4 (link), or LUI immediate.
- Performs byte/halfword/word load extraction with sign or zero extension.
- Waits on variable-latency memory read data, with a watchdog timeout.
- Issues a single-cycle register-file write pulse and back-pressures the MEM stage while a load is outstanding.

Parameters:
- XLEN, 32, datapath width; must be >= 32.
- PC_W, 10, width of the PC+4 input; must be <= XLEN.
- RF_AW, 5, register-file address width.
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before the load is abandoned; must be >= 1.

Ports:
- clk, in, 1, clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, MEM stage presents an instruction.
- in_ready, out, 1, stage can accept; high only in IDLE.
- in_regwrite, in, 1, instruction writes rd.
- in_rd, in, RF_AW, destination register.
- in_sel, in, 2, source select: 00 ALU, 01 load, 10 PC+4, 11 LUI.
- in_jal, in, 1, link write; overrides in_sel and forces PC+4.
- in_alu, in, XLEN, ALU result.
- in_pc4, in, PC_W, PC+4.
- in_instr, in, 32, instruction word (LUI immediate source).
- in_ld_size, in, 2, load size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- in_ld_unsigned, in, 1, zero-extend instead of sign-extend.
- in_addr_lo, in, 2, load address bits [1:0].
- mem_rvalid, in, 1, load data valid.
- mem_rdata, in, 32, aligned memory word.
- rf_we, out, 1, register-file write strobe.
- rf_waddr, out, RF_AW, write address.
- rf_wdata, out, XLEN, write data.
- err_misalign, out, 1, one-cycle pulse: misaligned load dropped.
- err_timeout, out, 1, sticky flag: load timed out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, err_misalign=0, err_timeout=0.
  - in_ready=1 as soon as rst_n deasserts.
- All outputs except in_ready are registered; in_ready = (state==IDLE).
- Accept: in_valid && in_ready at a rising edge. Inputs are captured only on accept; the op fields needed for the load are held internally.
- Effective source: jal ? PC+4 : in_sel.
- Data formation:
  - ALU → in_alu.
  - PC+4 → zero-extended to XLEN.
  - LUI → {in_instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN>32.
- Non-load accept (IDLE→IDLE):
  - Next cycle rf_we = in_regwrite && (in_rd!=0), with rf_waddr/rf_wdata set.
  - Latency 1 cycle; back-to-back throughput 1/cycle.
- Load accept:
  - Misaligned case: half with addr_lo[0]=1, or word with addr_lo!=0.
    - Next cycle err_misalign=1 and rf_we=0.
    - Stay in IDLE; no memory wait.
  - Aligned case: IDLE→WAIT_MEM, counter cleared.
- WAIT_MEM:
  - mem_rvalid is sampled only here; it is ignored in IDLE.
  - On mem_rvalid:
    - Extract byte mem_rdata[8*addr_lo+:8] or half mem_rdata[16*addr_lo[1]+:16].
    - Extend per in_ld_unsigned; word loads sign- or zero-extend to XLEN.
    - Next cycle rf_we = regwrite && rd!=0; go to IDLE.
  - Without mem_rvalid: counter increments.
    - When the counter reaches MEM_TIMEOUT-1 with no mem_rvalid → IDLE, err_timeout set (sticky until reset), no write.
  - mem_rvalid in the same cycle as the timeout takes priority: the data is written and no error is raised.
- Load latency = 1 (accept) + N (wait) + 1 (write) cycles.
- rf_we is high for exactly one cycle per write; rf_waddr/rf_wdata hold their last values while rf_we=0.
- A write to rd=0 is suppressed; the data path still updates.
- Reset mid-WAIT_MEM abandons the load with no write; a late mem_rvalid arriving in IDLE is ignored.

Decomposition:
- Shared package core_pkg holds:
  - WB_SEL_ALU/MEM/PC4/LUI (2-bit).
  - LD_BYTE/HALF/WORD.
  - The wb_state_t enum {IDLE, WAIT_MEM}.
- One sub-module, load_extend: combinational extraction and sign/zero extension from (mem_rdata, ld_size, ld_unsigned, addr_lo) to an XLEN-wide result.
- The state machine, watchdog counter and output registers stay in wb_stage.

Test Plan:
- ALU op: accept sel=00, rd=3, alu=32'h1234_5678 → next cycle rf_we=1, waddr=3, wdata=32'h1234_5678. Back-to-back ops give one write per cycle.
- JAL with sel=01: jal=1, pc4=10'h3FC, rd=1 → wdata=32'h0000_03FC, no WAIT_MEM, in_ready stays 1.
- LUI: sel=11, instr=32'hABCDE0B7 → wdata=32'hABCDE000.
- Signed byte load: size=00, addr_lo=3, rdata=32'h80FF_1122, mem_rvalid 3 cycles after accept:
  - in_ready=0 for 3 cycles, then wdata=32'hFFFF_FF80.
  - With unsigned=1 → 32'h0000_0080.
- Misaligned half: size=01, addr_lo=1 → err_misalign pulses one cycle, rf_we=0, in_ready stays 1.
- Timeout:
  - No mem_rvalid for 15 cycles → state returns to IDLE, err_timeout=1 and sticky, no write.
  - A subsequent late mem_rvalid is ignored.
  - Repeat with rvalid on the 15th cycle → write occurs, no error.
  - Assert rst_n=0 mid-wait → all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the write-back stage: source selects, load sizes,
// the write-back FSM state type and the held load-operation record.
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_LUI = 2'b11;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Load attributes held while the memory read is outstanding.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] addr_lo;
  } ld_op_t;

  // Half loads must be 2-byte aligned, word (and reserved) loads 4-byte aligned.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == LD_HALF) mis = addr_lo[0];
    else if (size != LD_BYTE) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the byte/half/word from an aligned
// memory word and sign- or zero-extends it to XLEN.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     mem_rdata,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; reserved size behaves as a word load.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_size)
      LD_BYTE: result = ld_unsigned ? XLEN'(byte_sel) : XLEN'($signed(byte_sel));
      LD_HALF: result = ld_unsigned ? XLEN'(half_sel) : XLEN'($signed(half_sel));
      default: result = ld_unsigned ? XLEN'(mem_rdata) : XLEN'($signed(mem_rdata));
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: forms register-file write data from ALU, load,
// link or LUI sources, waits for load data with a watchdog, and stalls the MEM
// stage while a load is outstanding.
//
// Handshake: an instruction is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready is high exactly when the FSM is in IDLE and
// inputs are only sampled on accept. mem_rvalid carries no ready: it is
// consumed on any edge where the FSM is in WAIT_MEM and ignored otherwise.
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_W        = 10,
  parameter int RF_AW       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regwrite,
  input  logic [RF_AW-1:0] in_rd,
  input  logic [1:0]       in_sel,
  input  logic             in_jal,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [PC_W-1:0]  in_pc4,
  input  logic [31:0]      in_instr,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic [1:0]       in_addr_lo,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             err_misalign,
  output logic             err_timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ld_op_t           ld_q, ld_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             err_misalign_q, err_misalign_d;
  logic             err_timeout_q, err_timeout_d;

  logic [1:0]       eff_sel;
  logic [31:0]      lui_imm;
  logic [XLEN-1:0]  src_data;
  logic [XLEN-1:0]  ld_result;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .mem_rdata   (mem_rdata),
    .ld_size     (ld_q.size),
    .ld_unsigned (ld_q.uns),
    .addr_lo     (ld_q.addr_lo),
    .result      (ld_result)
  );

  // Non-load write data: jal forces the link source regardless of in_sel.
  always_comb begin
    eff_sel = in_jal ? WB_SEL_PC4 : in_sel;
    lui_imm = in_instr & 32'hFFFF_F000;
    case (eff_sel)
      WB_SEL_PC4: src_data = XLEN'(in_pc4);
      WB_SEL_LUI: src_data = XLEN'($signed(lui_imm));
      default:    src_data = in_alu;
    endcase
  end

  // Next-state, watchdog and output register computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_d           = ld_q;
    rd_d           = rd_q;
    regwrite_d     = regwrite_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    err_misalign_d = 1'b0;
    err_timeout_d  = err_timeout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (eff_sel == WB_SEL_MEM) begin
            if (ld_misaligned(in_ld_size, in_addr_lo)) begin
              err_misalign_d = 1'b1;
            end else begin
              state_d    = WAIT_MEM;
              cnt_d      = '0;
              ld_d       = '{size: in_ld_size, uns: in_ld_unsigned, addr_lo: in_addr_lo};
              rd_d       = in_rd;
              regwrite_d = in_regwrite;
            end
          end else begin
            rf_we_d    = in_regwrite && (in_rd != '0);
            rf_waddr_d = in_rd;
            rf_wdata_d = src_data;
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the final watchdog cycle still wins.
        if (mem_rvalid) begin
          state_d    = IDLE;
          rf_we_d    = regwrite_q && (rd_q != '0);
          rf_waddr_d = rd_q;
          rf_wdata_d = ld_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ld_q           <= '0;
      rd_q           <= '0;
      regwrite_q     <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_q           <= ld_d;
      rd_q           <= rd_d;
      regwrite_q     <= regwrite_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_sel;
  logic        in_jal;
  logic [31:0] in_alu;
  logic [9:0]  in_pc4;
  logic [31:0] in_instr;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_misalign;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_regwrite    (in_regwrite),
    .in_rd          (in_rd),
    .in_sel         (in_sel),
    .in_jal         (in_jal),
    .in_alu         (in_alu),
    .in_pc4         (in_pc4),
    .in_instr       (in_instr),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_addr_lo     (in_addr_lo),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .err_misalign   (err_misalign),
    .err_timeout    (err_timeout)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for exactly one edge, then drop in_valid.
  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic jal, input logic [31:0] alu, input logic [9:0] pc4,
                      input logic [31:0] instr, input logic [1:0] sz, input logic uns,
                      input logic [1:0] alo);
    in_valid       = 1'b1;
    in_regwrite    = rw;
    in_rd          = rd;
    in_sel         = sel;
    in_jal         = jal;
    in_alu         = alu;
    in_pc4         = pc4;
    in_instr       = instr;
    in_ld_size     = sz;
    in_ld_unsigned = uns;
    in_addr_lo     = alo;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                      input logic [1:0] alo);
    send(1'b1, rd, 2'b01, 1'b0, 32'h0, 10'h0, 32'h0, sz, uns, alo);
  endtask

  // Deliver memory data on the next edge.
  task automatic mem_return(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_sel = '0;
    in_jal = 1'b0; in_alu = '0; in_pc4 = '0; in_instr = '0; in_ld_size = '0;
    in_ld_unsigned = 1'b0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    #12;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_errs", {err_misalign, err_timeout}, 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);

    // ALU op
    send(1'b1, 5'd3, 2'b00, 1'b0, 32'h1234_5678, 10'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 3);
    check("alu_wdata", rf_wdata, 32'h1234_5678);

    // Back-to-back ALU ops, one write per cycle
    send(1'b1, 5'd4, 2'b00, 1'b0, 32'hAAAA_0001, 10'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    check("b2b0_we", rf_we, 1);
    check("b2b0_data", {27'h0, rf_waddr} ^ rf_wdata, 32'hAAAA_0005);
    send(1'b1, 5'd5, 2'b00, 1'b0, 32'hBBBB_0002, 10'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    check("b2b1_we", rf_we, 1);
    check("b2b1_waddr", rf_waddr, 5);
    check("b2b1_wdata", rf_wdata, 32'hBBBB_0002);
    tick();
    check("idle_we", rf_we, 0);
    check("idle_hold", rf_wdata, 32'hBBBB_0002);

    // JAL overrides a load select
    send(1'b1, 5'd1, 2'b01, 1'b1, 32'h0, 10'h3FC, 32'h0, 2'b10, 1'b0, 2'b00);
    check("jal_ready", in_ready, 1);
    check("jal_we", rf_we, 1);
    check("jal_wdata", rf_wdata, 32'h0000_03FC);

    // LUI
    send(1'b1, 5'd7, 2'b11, 1'b0, 32'h0, 10'h0, 32'hABCDE0B7, 2'b00, 1'b0, 2'b00);
    check("lui_wdata", rf_wdata, 32'hABCD_E000);
    check("lui_waddr", rf_waddr, 7);

    // rd=0: write suppressed, data path still updates
    send(1'b1, 5'd0, 2'b00, 1'b0, 32'h0000_0055, 10'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    check("rd0_we", rf_we, 0);
    check("rd0_wdata", rf_wdata, 32'h0000_0055);

    // Signed byte load, data 3 cycles after accept
    load(5'd9, 2'b00, 1'b0, 2'd3);
    check("ldb_ready0", in_ready, 0);
    check("ldb_we0", rf_we, 0);
    tick();
    check("ldb_ready1", in_ready, 0);
    tick();
    check("ldb_ready2", in_ready, 0);
    mem_return(32'h80FF_1122);
    check("ldb_we", rf_we, 1);
    check("ldb_waddr", rf_waddr, 9);
    check("ldb_wdata", rf_wdata, 32'hFFFF_FF80);
    check("ldb_ready3", in_ready, 1);
    tick();
    check("ldb_pulse", rf_we, 0);

    // Unsigned byte load
    load(5'd9, 2'b00, 1'b1, 2'd3);
    mem_return(32'h80FF_1122);
    check("ldbu_wdata", rf_wdata, 32'h0000_0080);

    // Signed half, upper lane
    load(5'd10, 2'b01, 1'b0, 2'd2);
    mem_return(32'h8001_1234);
    check("ldh_wdata", rf_wdata, 32'hFFFF_8001);

    // Signed byte, lane 1
    load(5'd11, 2'b00, 1'b0, 2'd1);
    mem_return(32'h0000_7F00);
    check("ldb1_wdata", rf_wdata, 32'h0000_007F);

    // Word load
    load(5'd12, 2'b10, 1'b0, 2'd0);
    mem_return(32'hDEAD_BEEF);
    check("ldw_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("ldw_waddr", rf_waddr, 12);

    // Misaligned half
    load(5'd13, 2'b01, 1'b0, 2'd1);
    check("mis_pulse", err_misalign, 1);
    check("mis_we", rf_we, 0);
    check("mis_ready", in_ready, 1);
    check("mis_hold", rf_wdata, 32'hDEAD_BEEF);
    tick();
    check("mis_clear", err_misalign, 0);

    // Misaligned word
    load(5'd13, 2'b10, 1'b0, 2'd2);
    check("misw_pulse", err_misalign, 1);

    // Late rvalid in IDLE ignored
    mem_return(32'h1111_1111);
    check("idle_rvalid_we", rf_we, 0);

    // Timeout: 15 cycles in WAIT_MEM with no data
    load(5'd14, 2'b10, 1'b0, 2'd0);
    for (int i = 0; i < 14; i++) tick();
    check("to_ready14", in_ready, 0);
    check("to_err14", err_timeout, 0);
    tick();
    check("to_ready", in_ready, 1);
    check("to_err", err_timeout, 1);
    check("to_we", rf_we, 0);
    mem_return(32'h2222_2222);
    check("to_late_we", rf_we, 0);
    check("to_sticky", err_timeout, 1);
    tick();
    check("to_sticky2", err_timeout, 1);

    // rvalid on the 15th cycle wins over the watchdog
    do_reset();
    check("rst2_err", err_timeout, 0);
    load(5'd15, 2'b10, 1'b0, 2'd0);
    for (int i = 0; i < 14; i++) tick();
    mem_return(32'h0BAD_F00D);
    check("edge_we", rf_we, 1);
    check("edge_wdata", rf_wdata, 32'h0BAD_F00D);
    check("edge_err", err_timeout, 0);

    // Reset mid-wait abandons the load
    load(5'd16, 2'b10, 1'b0, 2'd0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_outs", {rf_we, err_misalign, err_timeout, 27'h0, rf_waddr}, 0);
    check("mrst_wdata", rf_wdata, 0);
    check("mrst_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    mem_return(32'h3333_3333);
    check("mrst_late_we", rf_we, 0);
    check("mrst_late_data", rf_wdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
